cm_idx_gen: RTL and testbench

Three-level nested index generator with a valid/ready output handshake; it is the producing side of the per-dimension wrap counting used across the cnna datapath. On a start pulse it latches three upper bounds and emits every index tuple (idx2, idx1, idx0) exactly once, innermost dimension fastest. Downstream consumers (ibuf/obuf read address formers, weight fetch sequencers) advance on each accepted beat. The block ends with a one-cycle done pulse.

---
 rtl/cm_pkg.sv | 12 +
 rtl/cm_idx_dim.sv | 35 +++
 rtl/cm_idx_gen.sv | 97 +++++++++
 tb/tb_cm_idx_gen.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cm_pkg.sv
// Shared definitions for the cm index generator: FSM encoding and default width.
package cm_pkg;

  localparam int C_WIDTH_DEF = 8;

  typedef logic [1:0] cm_state_t;

  localparam cm_state_t ST_IDLE = 2'd0;
  localparam cm_state_t ST_RUN  = 2'd1;
  localparam cm_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/cm_idx_dim.sv
// One dimension of the nested index counter: compare-based wrap, no overflow.
module cm_idx_dim #(
  parameter int C_WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               step_i,
  input  logic [C_WIDTH-1:0] upper_i,
  output logic [C_WIDTH-1:0] idx_o,
  output logic               wrap_o,
  output logic               last_o
);

  logic [C_WIDTH-1:0] idx_q, idx_d;

  // Last flag and carry out come straight from registered index vs latched bound.
  assign last_o = (idx_q == upper_i);
  assign wrap_o = step_i && last_o;
  assign idx_o  = idx_q;

  // Next index: abort clears, a step either wraps at the bound or increments.
  always_comb begin
    idx_d = idx_q;
    if (clr_i)       idx_d = '0;
    else if (step_i) idx_d = last_o ? '0 : idx_q + 1'b1;
  end

  // Index register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) idx_q <= '0;
    else         idx_q <= idx_d;
  end

endmodule

// File: rtl/cm_idx_gen.sv
// Three-level nested index generator with valid/ready output and done pulse.
module cm_idx_gen
  import cm_pkg::*;
#(
  parameter int C_WIDTH = C_WIDTH_DEF
) (
  input  logic               I_clk,
  input  logic               I_rst_n,
  input  logic               I_start,
  input  logic               I_clr,
  input  logic [C_WIDTH-1:0] I_upper0,
  input  logic [C_WIDTH-1:0] I_upper1,
  input  logic [C_WIDTH-1:0] I_upper2,
  output logic               O_valid,
  input  logic               I_ready,
  output logic [C_WIDTH-1:0] O_idx0,
  output logic [C_WIDTH-1:0] O_idx1,
  output logic [C_WIDTH-1:0] O_idx2,
  output logic               O_last0,
  output logic               O_last1,
  output logic               O_last2,
  output logic               O_busy,
  output logic               O_done
);

  cm_state_t state_q, state_d;

  logic [2:0][C_WIDTH-1:0] upper_q, upper_d;
  logic [2:0][C_WIDTH-1:0] idx;
  logic [2:0]              step, wrap, last;
  logic                    accept;

  // Abort wins over acceptance so a cleared cycle never advances indices.
  assign accept = (state_q == ST_RUN) && I_ready && !I_clr;

  // Carry chain: dim N steps only when dim N-1 wraps.
  assign step[0] = accept;
  assign step[1] = wrap[0];
  assign step[2] = wrap[1];

  for (genvar d = 0; d < 3; d++) begin : g_dim
    cm_idx_dim #(.C_WIDTH(C_WIDTH)) u_dim (
      .clk_i  (I_clk),
      .rst_ni (I_rst_n),
      .clr_i  (I_clr),
      .step_i (step[d]),
      .upper_i(upper_q[d]),
      .idx_o  (idx[d]),
      .wrap_o (wrap[d]),
      .last_o (last[d])
    );
  end

  // Bounds are captured only on an honoured start; later input changes are ignored.
  always_comb begin
    upper_d = upper_q;
    if (state_q == ST_IDLE && I_start && !I_clr) upper_d = {I_upper2, I_upper1, I_upper0};
  end

  // Bound latch register.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) upper_q <= '0;
    else          upper_q <= upper_d;
  end

  // FSM state register.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state; the outermost wrap is exactly the accepted all-last beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (I_start) state_d = ST_RUN;
      ST_RUN:  if (wrap[2]) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (I_clr) state_d = ST_IDLE;
  end

  // FSM outputs; last flags are masked so idle zero bounds never show as last.
  always_comb begin
    O_valid = (state_q == ST_RUN);
    O_busy  = (state_q == ST_RUN) || (state_q == ST_DONE);
    O_done  = (state_q == ST_DONE);
    O_idx0  = idx[0];
    O_idx1  = idx[1];
    O_idx2  = idx[2];
    O_last0 = O_valid && last[0];
    O_last1 = O_valid && last[1];
    O_last2 = O_valid && last[2];
  end

endmodule

// File: tb/tb_cm_idx_gen.sv
// Directed self-checking bench for cm_idx_gen (C_WIDTH = 4).
module tb_cm_idx_gen;

  localparam int W = 4;

  logic         I_clk = 1'b0;
  logic         I_rst_n, I_start, I_clr, I_ready;
  logic [W-1:0] I_upper0, I_upper1, I_upper2;
  logic         O_valid, O_last0, O_last1, O_last2, O_busy, O_done;
  logic [W-1:0] O_idx0, O_idx1, O_idx2;

  int ntests = 0;
  int nerr   = 0;

  cm_idx_gen #(.C_WIDTH(W)) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_start(I_start), .I_clr(I_clr),
    .I_upper0(I_upper0), .I_upper1(I_upper1), .I_upper2(I_upper2),
    .O_valid(O_valid), .I_ready(I_ready),
    .O_idx0(O_idx0), .O_idx1(O_idx1), .O_idx2(O_idx2),
    .O_last0(O_last0), .O_last1(O_last1), .O_last2(O_last2),
    .O_busy(O_busy), .O_done(O_done)
  );

  always #5 I_clk = ~I_clk;

  // {valid, busy, done, idx2, idx1, idx0, last2, last1, last0}
  logic [3*W+5:0] obs;
  assign obs = {O_valid, O_busy, O_done, O_idx2, O_idx1, O_idx0, O_last2, O_last1, O_last0};

  localparam logic [3*W+5:0] IDLE_VEC = '0;
  localparam logic [3*W+5:0] DONE_VEC = {3'b011, {(3*W+3){1'b0}}};

  task automatic tick;
    @(posedge I_clk);
    #1;
  endtask

  // Start with the given bounds and walk every tuple in nested order.
  // stall: ready pattern 1,0,0 repeating. glitch_at: beat where start is re-pulsed
  // with different bounds (-1 for none).
  task automatic run_seq(input int u2, input int u1, input int u0,
                         input bit stall, input int glitch_at);
    int cyc = 0;
    int beat = 0;
    logic [3*W+5:0] exp;
    bit acc;
    I_upper2 = 4'(u2); I_upper1 = 4'(u1); I_upper0 = 4'(u0);
    I_start = 1'b1;
    tick;
    I_start = 1'b0;
    for (int i2 = 0; i2 <= u2; i2++)
      for (int i1 = 0; i1 <= u1; i1++)
        for (int i0 = 0; i0 <= u0; i0++) begin
          exp = {3'b110, 4'(i2), 4'(i1), 4'(i0),
                 (i2 == u2), (i1 == u1), (i0 == u0)};
          acc = 1'b0;
          while (!acc) begin
            I_ready = stall ? (cyc % 3 == 0) : 1'b1;
            if (beat == glitch_at) begin
              I_start = 1'b1;
              I_upper2 = ~4'(u2); I_upper1 = ~4'(u1); I_upper0 = ~4'(u0);
            end else begin
              I_start = 1'b0;
            end
            ntests++;
            if (obs !== exp) begin
              nerr++;
              $display("FAIL beat%0d: got %h expected %h", beat, obs, exp);
            end
            acc = I_ready;
            tick;
            cyc++;
            if (cyc > 500) begin
              nerr++;
              $display("FAIL seq_timeout: got %0d cycles expected <= 500", cyc);
              I_start = 1'b0;
              return;
            end
          end
          beat++;
        end
    I_start = 1'b0;
    I_ready = 1'b1;
    ntests++;
    if (obs !== DONE_VEC) begin
      nerr++;
      $display("FAIL done_pulse: got %h expected %h", obs, DONE_VEC);
    end
    tick;
    ntests++;
    if (obs !== IDLE_VEC) begin
      nerr++;
      $display("FAIL back_to_idle: got %h expected %h", obs, IDLE_VEC);
    end
  endtask

  task automatic test_reset;
    I_rst_n = 1'b0; I_start = 1'b0; I_clr = 1'b0; I_ready = 1'b0;
    I_upper0 = '0; I_upper1 = '0; I_upper2 = '0;
    tick; tick;
    ntests++;
    if (obs !== IDLE_VEC) begin
      nerr++;
      $display("FAIL reset_state: got %h expected %h", obs, IDLE_VEC);
    end
    I_rst_n = 1'b1;
    tick;
    ntests++;
    if (obs !== IDLE_VEC) begin
      nerr++;
      $display("FAIL post_reset_idle: got %h expected %h", obs, IDLE_VEC);
    end
  endtask

  task automatic test_basic;         run_seq(0, 1, 2, 1'b0, -1); endtask
  task automatic test_backpressure;  run_seq(0, 1, 2, 1'b1, -1); endtask
  task automatic test_zero_bounds;   run_seq(0, 0, 0, 1'b0, -1); endtask
  task automatic test_start_ignored; run_seq(1, 1, 1, 1'b0, 3);  endtask
  task automatic test_back_to_back;
    run_seq(0, 0, 1, 1'b0, -1);
    run_seq(1, 0, 0, 1'b0, -1);
  endtask

  task automatic test_clr;
    logic [3*W+5:0] exp;
    I_upper2 = 4'd1; I_upper1 = 4'd1; I_upper0 = 4'd1; I_ready = 1'b1;
    I_start = 1'b1;
    tick;
    I_start = 1'b0;
    repeat (4) tick;
    exp = {3'b110, 4'd1, 4'd0, 4'd0, 3'b100};
    ntests++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL clr_beat4: got %h expected %h", obs, exp);
    end
    I_clr = 1'b1;
    I_start = 1'b1;
    tick;
    I_clr = 1'b0;
    I_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ntests++;
      if (obs !== IDLE_VEC) begin
        nerr++;
        $display("FAIL clr_idle%0d: got %h expected %h", k, obs, IDLE_VEC);
      end
      tick;
    end
    run_seq(1, 1, 1, 1'b0, -1);
  endtask

  task automatic test_reset_mid_run;
    I_upper2 = 4'd0; I_upper1 = 4'd0; I_upper0 = 4'd15; I_ready = 1'b1;
    I_start = 1'b1;
    tick;
    I_start = 1'b0;
    repeat (5) tick;
    #2;
    I_rst_n = 1'b0;
    #1;
    ntests++;
    if (obs !== IDLE_VEC) begin
      nerr++;
      $display("FAIL async_reset: got %h expected %h", obs, IDLE_VEC);
    end
    tick;
    I_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      ntests++;
      if (obs !== IDLE_VEC) begin
        nerr++;
        $display("FAIL reset_no_done%0d: got %h expected %h", k, obs, IDLE_VEC);
      end
    end
    run_seq(1, 0, 15, 1'b0, -1);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_zero_bounds;
    test_start_ignored;
    test_back_to_back;
    test_clr;
    test_reset_mid_run;
    $display("[TB] %0d tests run, %0d failed", ntests, nerr);
    $finish;
  end

endmodule
